// File: rtl/mxv_fifo_reader.sv
// Matrix-times-vector reader: drains row/vector FIFOs and emits one dot product per row.
// Optional MXV_RECIRC_EN pushes each popped vector element back into the vector FIFO.
module mxv_fifo_reader #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [3:0]          n,
    input  logic [8*DATA_W-1:0] row_data,
    input  logic [7:0]          row_empty,
    output logic [7:0]          row_pop,
    input  logic [DATA_W-1:0]   vec_data,
    input  logic                vec_empty,
    output logic                vec_pop,
    output logic                vec_push,
    output logic [DATA_W-1:0]   vec_wdata,
    output logic [ACC_W-1:0]    result,
    output logic [2:0]          result_row,
    output logic                result_valid,
    input  logic                result_ready,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_EMIT, ST_DONE} state_t;

    state_t              state_q;
    logic [3:0]          n_q;
    logic [2:0]          row_q;
    logic [2:0]          col_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_d;
    logic [ACC_W-1:0]    result_q;
    logic [2:0]          result_row_q;
    logic                result_valid_q;
    logic                busy_q;
    logic                done_q;

    logic [DATA_W-1:0]   head_s;
    logic [2*DATA_W-1:0] prod_s;
    logic                fire_s;
    logic                last_col_s;
    logic                last_row_s;
    logic                n_ok_s;

    // Select the head element of the row FIFO currently being consumed.
    always_comb begin
        head_s = '0;
        for (int k = 0; k < 8; k++) begin
            if (row_q == 3'(k)) begin
                head_s = row_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign fire_s     = (state_q == ST_MAC) && !row_empty[row_q] && !vec_empty;
    assign prod_s     = (2*DATA_W)'(head_s) * (2*DATA_W)'(vec_data);
    assign acc_d      = acc_q + ACC_W'(prod_s);
    assign last_col_s = ({1'b0, col_q} == (n_q - 4'd1));
    assign last_row_s = ({1'b0, row_q} == (n_q - 4'd1));
    assign n_ok_s     = (n != 4'd0) && (n <= 4'd8);

    // Pops are combinational so one element is consumed per cycle without a bubble.
    assign row_pop = fire_s ? (8'd1 << row_q) : 8'd0;
    assign vec_pop = fire_s;

`ifdef MXV_RECIRC_EN
    assign vec_push  = fire_s;
    assign vec_wdata = fire_s ? vec_data : '0;
`else
    assign vec_push  = 1'b0;
    assign vec_wdata = '0;
`endif

    assign result       = result_q;
    assign result_row   = result_row_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

    // Control FSM with registered result, valid, busy and done.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            n_q            <= 4'd0;
            row_q          <= 3'd0;
            col_q          <= 3'd0;
            acc_q          <= '0;
            result_q       <= '0;
            result_row_q   <= 3'd0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && n_ok_s) begin
                        n_q     <= n;
                        row_q   <= 3'd0;
                        col_q   <= 3'd0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (fire_s) begin
                        acc_q <= acc_d;
                        if (last_col_s) begin
                            result_q       <= acc_d;
                            result_row_q   <= row_q;
                            result_valid_q <= 1'b1;
                            state_q        <= ST_EMIT;
                        end else begin
                            col_q <= col_q + 3'd1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (result_ready) begin
                        result_valid_q <= 1'b0;
                        if (last_row_s) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            row_q   <= row_q + 3'd1;
                            col_q   <= 3'd0;
                            acc_q   <= '0;
                            state_q <= ST_MAC;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    result_valid_q <= 1'b0;
                    done_q         <= 1'b0;
                    busy_q         <= 1'b0;
                    state_q        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mxv_fifo_reader.sv
// Directed bench for mxv_fifo_reader with show-ahead FIFO models for rows and vector.
module tb_mxv_fifo_reader;

`ifdef MXV_RECIRC_EN
    localparam bit RECIRC = 1'b1;
`else
    localparam bit RECIRC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, result_ready;
    logic [3:0]  n;
    logic [63:0] row_data;
    logic [7:0]  row_empty, row_pop;
    logic [7:0]  vec_data, vec_wdata;
    logic        vec_empty, vec_pop, vec_push;
    logic [19:0] result;
    logic [2:0]  result_row;
    logic        result_valid, busy, done;

    logic [7:0]  rmem [8][128];
    logic [6:0]  rrd [8];
    logic [6:0]  rwr [8];
    logic [7:0]  vmem [128];
    logic [6:0]  vrd, vwr;
    logic [7:0]  stall_mask;

    int          checks = 0;
    int          errors = 0;
    int          cyc, vpops, nres, done_cyc, stall_left;
    bit          stall_arm;
    logic [19:0] res_val [8];
    logic [2:0]  res_row [8];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_row
            assign row_data[g*8 +: 8] = rmem[g][rrd[g]];
            assign row_empty[g]       = (rrd[g] == rwr[g]) || stall_mask[g];
        end
    endgenerate
    assign vec_data  = vmem[vrd];
    assign vec_empty = (vrd == vwr);

    mxv_fifo_reader #(.DATA_W(8), .ACC_W(20)) dut (
        .clk(clk), .reset(reset), .start(start), .n(n),
        .row_data(row_data), .row_empty(row_empty), .row_pop(row_pop),
        .vec_data(vec_data), .vec_empty(vec_empty), .vec_pop(vec_pop),
        .vec_push(vec_push), .vec_wdata(vec_wdata),
        .result(result), .result_row(result_row), .result_valid(result_valid),
        .result_ready(result_ready), .busy(busy), .done(done)
    );

    task automatic clear_fifos();
        for (int k = 0; k < 8; k++) begin
            rrd[k] = 7'd0;
            rwr[k] = 7'd0;
        end
        vrd = 7'd0;
        vwr = 7'd0;
        stall_mask = 8'd0;
        stall_arm = 1'b0;
        stall_left = 0;
    endtask

    task automatic push_row(input int k, input logic [7:0] v);
        rmem[k][rwr[k]] = v;
        rwr[k] = rwr[k] + 7'd1;
    endtask

    task automatic push_vec(input logic [7:0] v);
        vmem[vwr] = v;
        vwr = vwr + 7'd1;
    endtask

    function automatic int vreps(input int nn);
        return RECIRC ? 1 : nn;
    endfunction

    // Sample the current cycle at the falling edge, then apply FIFO updates after the rising edge.
    task automatic tick();
        logic [7:0] p_row;
        logic       p_vec, p_push;
        logic [7:0] p_wd;
        @(negedge clk);
        p_row = row_pop; p_vec = vec_pop; p_push = vec_push; p_wd = vec_wdata;
        if (result_valid === 1'b1 && result_ready === 1'b1 && nres < 8) begin
            res_val[nres] = result;
            res_row[nres] = result_row;
            nres++;
        end
        if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
        if (p_vec === 1'b1) vpops++;
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) if (p_row[k] === 1'b1) rrd[k] = rrd[k] + 7'd1;
        if (p_vec === 1'b1) vrd = vrd + 7'd1;
        if (p_push === 1'b1) push_vec(p_wd);
        if (stall_arm && p_row[0] === 1'b1) begin
            stall_mask[0] = 1'b1;
            stall_left = 3;
            stall_arm = 1'b0;
        end else if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) stall_mask[0] = 1'b0;
        end
        cyc++;
    endtask

    task automatic do_start(input logic [3:0] nv);
        start = 1'b1; n = nv;
        cyc = 0; vpops = 0; nres = 0; done_cyc = -1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int maxc);
        for (int i = 0; i < maxc && done_cyc < 0; i++) tick();
    endtask

    task automatic load_basic();
        clear_fifos();
        push_row(0, 8'd1); push_row(0, 8'd2);
        push_row(1, 8'd3); push_row(1, 8'd4);
        for (int r = 0; r < vreps(2); r++) begin
            push_vec(8'd5); push_vec(8'd6);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; n = 4'd0; result_ready = 1'b1;
        clear_fifos();
        tick(); tick();
        checks += 9;
        if (row_pop !== 8'd0) begin errors++; $display("FAIL reset_row_pop: got %h expected 00", row_pop); end
        if (vec_pop !== 1'b0) begin errors++; $display("FAIL reset_vec_pop: got %b expected 0", vec_pop); end
        if (vec_push !== 1'b0) begin errors++; $display("FAIL reset_vec_push: got %b expected 0", vec_push); end
        if (vec_wdata !== 8'd0) begin errors++; $display("FAIL reset_vec_wdata: got %h expected 00", vec_wdata); end
        if (result !== 20'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
        if (result_row !== 3'd0) begin errors++; $display("FAIL reset_result_row: got %0d expected 0", result_row); end
        if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [6:0] nxt;
        load_basic();
        result_ready = 1'b1;
        do_start(4'd2);
        run_to_done(40);
        checks += 7;
        if (nres != 2) begin errors++; $display("FAIL basic_count: got %0d expected 2", nres); end
        if (res_val[0] !== 20'd17) begin errors++; $display("FAIL basic_res0: got %0d expected 17", res_val[0]); end
        if (res_row[0] !== 3'd0) begin errors++; $display("FAIL basic_row0: got %0d expected 0", res_row[0]); end
        if (res_val[1] !== 20'd39) begin errors++; $display("FAIL basic_res1: got %0d expected 39", res_val[1]); end
        if (res_row[1] !== 3'd1) begin errors++; $display("FAIL basic_row1: got %0d expected 1", res_row[1]); end
        if (done_cyc != 7) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 7", done_cyc); end
        if (vpops != 4) begin errors++; $display("FAIL basic_vec_pops: got %0d expected 4", vpops); end
`ifdef MXV_RECIRC_EN
        nxt = vrd + 7'd1;
        checks += 3;
        if (7'(vwr - vrd) != 7'd2) begin errors++; $display("FAIL basic_vec_level: got %0d expected 2", 7'(vwr - vrd)); end
        if (vmem[vrd] !== 8'd5) begin errors++; $display("FAIL basic_vec_head: got %0d expected 5", vmem[vrd]); end
        if (vmem[nxt] !== 8'd6) begin errors++; $display("FAIL basic_vec_second: got %0d expected 6", vmem[nxt]); end
`else
        nxt = vwr;
        checks += 1;
        if (vrd !== nxt) begin errors++; $display("FAIL basic_vec_drained: got rd %0d expected %0d", vrd, nxt); end
`endif
    endtask

    task automatic test_full();
        clear_fifos();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) push_row(r, 8'd255);
        for (int i = 0; i < 8 * vreps(8); i++) push_vec(8'd255);
        result_ready = 1'b1;
        do_start(4'd8);
        run_to_done(200);
        checks += 2;
        if (nres != 8) begin errors++; $display("FAIL full_count: got %0d expected 8", nres); end
        if (done_cyc != 73) begin errors++; $display("FAIL full_done_cycle: got %0d expected 73", done_cyc); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (res_val[i] !== 20'd520200 || res_row[i] !== 3'(i)) begin
                errors++;
                $display("FAIL full_row%0d: got %0d row %0d expected 520200 row %0d", i, res_val[i], res_row[i], i);
            end
        end
    endtask

    task automatic test_stall();
        clear_fifos();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) push_row(r, 8'(3 * r + c + 1));
        for (int i = 0; i < vreps(3); i++) begin
            push_vec(8'd1); push_vec(8'd2); push_vec(8'd3);
        end
        result_ready = 1'b1;
        stall_arm = 1'b1;
        do_start(4'd3);
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (vpops != 1) begin errors++; $display("FAIL stall_gap_pops: got %0d expected 1", vpops); end
        run_to_done(60);
        checks += 4;
        if (res_val[0] !== 20'd14) begin errors++; $display("FAIL stall_res0: got %0d expected 14", res_val[0]); end
        if (res_val[1] !== 20'd32) begin errors++; $display("FAIL stall_res1: got %0d expected 32", res_val[1]); end
        if (res_val[2] !== 20'd50) begin errors++; $display("FAIL stall_res2: got %0d expected 50", res_val[2]); end
        if (done_cyc != 16) begin errors++; $display("FAIL stall_done_cycle: got %0d expected 16", done_cyc); end
    endtask

    task automatic test_backpressure();
        int p;
        load_basic();
        result_ready = 1'b0;
        do_start(4'd2);
        for (int i = 0; i < 10 && result_valid !== 1'b1; i++) tick();
        checks++;
        if (result_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout: got %b expected 1", result_valid); end
        p = vpops;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (result !== 20'd17 || result_row !== 3'd0 || result_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d: got res %0d row %0d valid %b expected 17 0 1", i, result, result_row, result_valid);
            end
        end
        checks++;
        if (vpops != p) begin errors++; $display("FAIL bp_no_pops: got %0d expected %0d", vpops, p); end
        result_ready = 1'b1;
        run_to_done(40);
        checks += 4;
        if (res_val[0] !== 20'd17) begin errors++; $display("FAIL bp_res0: got %0d expected 17", res_val[0]); end
        if (res_val[1] !== 20'd39) begin errors++; $display("FAIL bp_res1: got %0d expected 39", res_val[1]); end
        if (res_row[1] !== 3'd1) begin errors++; $display("FAIL bp_row1: got %0d expected 1", res_row[1]); end
        if (done_cyc != 12) begin errors++; $display("FAIL bp_done_cycle: got %0d expected 12", done_cyc); end
    endtask

    task automatic test_midreset();
        load_basic();
        result_ready = 1'b1;
        do_start(4'd2);
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b0;
        tick();
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy: got %b expected 0", busy); end
        if (result_valid !== 1'b0 || result !== 20'd0 || result_row !== 3'd0) begin
            errors++;
            $display("FAIL mr_result: got valid %b res %0d row %0d expected 0 0 0", result_valid, result, result_row);
        end
        if (row_pop !== 8'd0 || vec_pop !== 1'b0) begin errors++; $display("FAIL mr_pops: got %h %b expected 00 0", row_pop, vec_pop); end
        if (done !== 1'b0) begin errors++; $display("FAIL mr_done: got %b expected 0", done); end
        reset = 1'b1;
        clear_fifos();
        push_row(0, 8'd7);
        push_vec(8'd9);
        do_start(4'd1);
        run_to_done(20);
        checks += 3;
        if (nres != 1) begin errors++; $display("FAIL mr_count: got %0d expected 1", nres); end
        if (res_val[0] !== 20'd63) begin errors++; $display("FAIL mr_res: got %0d expected 63", res_val[0]); end
        if (done_cyc != 3) begin errors++; $display("FAIL mr_done_cycle: got %0d expected 3", done_cyc); end
    endtask

    task automatic test_ignored_start();
        load_basic();
        result_ready = 1'b1;
        do_start(4'd0);
        for (int i = 0; i < 3; i++) tick();
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL ign_n0_busy: got %b expected 0", busy); end
        if (vpops != 0) begin errors++; $display("FAIL ign_n0_pops: got %0d expected 0", vpops); end
        do_start(4'd9);
        for (int i = 0; i < 3; i++) tick();
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL ign_n9_busy: got %b expected 0", busy); end
        if (vpops != 0) begin errors++; $display("FAIL ign_n9_pops: got %0d expected 0", vpops); end
        stall_mask[0] = 1'b1;
        do_start(4'd2);
        tick(); tick();
        start = 1'b1; n = 4'd1;
        tick();
        start = 1'b0; n = 4'd0;
        tick();
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy_held: got %b expected 1", busy); end
        if (vpops != 0) begin errors++; $display("FAIL ign_stall_pops: got %0d expected 0", vpops); end
        stall_mask[0] = 1'b0;
        run_to_done(40);
        checks += 4;
        if (nres != 2) begin errors++; $display("FAIL ign_count: got %0d expected 2", nres); end
        if (res_val[0] !== 20'd17) begin errors++; $display("FAIL ign_res0: got %0d expected 17", res_val[0]); end
        if (res_val[1] !== 20'd39) begin errors++; $display("FAIL ign_res1: got %0d expected 39", res_val[1]); end
        if (res_row[1] !== 3'd1) begin errors++; $display("FAIL ign_row1: got %0d expected 1", res_row[1]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_stall();
        test_backpressure();
        test_midreset();
        test_ignored_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
